// File: rtl/cordic_sincos.sv
// cordic_sincos: iterative rotation-mode CORDIC, integer-degree angle to Q1.14 cosine/sine
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   start    conversion request, sampled only while idle
//   angle_in signed integer degrees, clamped to -180..180
//   cos_out  signed Q1.14 cosine, registered
//   sin_out  signed Q1.14 sine, registered
//   done     one-cycle pulse when cos_out/sin_out update
//   busy     high while a conversion is in progress
// Build option: CORDIC_SINCOS_ROUND_EN rounds and saturates the outputs instead of truncating.
module cordic_sincos #(
  parameter int          ITER   = 16,
  parameter logic [31:0] K_INIT = 32'h26DD3B6A
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic signed [15:0] angle_in,
  output logic signed [15:0] cos_out,
  output logic signed [15:0] sin_out,
  output logic               done,
  output logic               busy
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  localparam logic [4:0] LAST = 5'(ITER - 1);
  // atan(2^-i) in degrees, Q16.16
  localparam logic signed [31:0] ATAN [16] = '{
    32'h002D0000, 32'h001A90A7, 32'h000E0947, 32'h00072001,
    32'h0003938B, 32'h0001CA38, 32'h0000E52A, 32'h00007297,
    32'h0000394C, 32'h00001CA6, 32'h00000E53, 32'h00000729,
    32'h00000395, 32'h000001CA, 32'h000000E5, 32'h00000073
  };
  state_t             r_state, w_next;
  logic signed [15:0] r_angle;
  logic signed [31:0] r_x, r_y, r_z;
  logic        [4:0]  r_i;
  logic               r_neg;
  logic signed [15:0] w_a, w_zdeg, w_cr, w_sr;
  logic signed [31:0] w_z0, w_xs, w_ys, w_atan;
  logic               w_neg, w_pos;
  // fold angles beyond +/-90 into the convergence range; the half-turn is undone by negating the result
  assign w_a    = r_angle > 16'sd180 ? 16'sd180 : r_angle < -16'sd180 ? -16'sd180 : r_angle;
  assign w_neg  = w_a > 16'sd90 || w_a < -16'sd90;
  assign w_zdeg = w_a > 16'sd90 ? w_a - 16'sd180 : w_a < -16'sd90 ? w_a + 16'sd180 : w_a;
  assign w_z0   = signed'({w_zdeg, 16'h0000});
  assign w_pos  = ~r_z[31];
  assign w_xs   = r_x >>> r_i;
  assign w_ys   = r_y >>> r_i;
  assign w_atan = ATAN[r_i[3:0]];
`ifdef CORDIC_SINCOS_ROUND_EN
  function automatic logic signed [15:0] sat(input logic signed [15:0] v);
    return v > 16'sd16384 ? 16'sd16384 : v < -16'sd16384 ? -16'sd16384 : v;
  endfunction
  // adding 0x8000 before taking [31:16] is the same as adding bit 15 to the upper half
  assign w_cr = sat(signed'(r_x[31:16] + {15'd0, r_x[15]}));
  assign w_sr = sat(signed'(r_y[31:16] + {15'd0, r_y[15]}));
`else
  assign w_cr = r_x[31:16];
  assign w_sr = r_y[31:16];
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = IDLE;
    w_next = r_state == IDLE ? (start ? LOAD : IDLE) :
             r_state == LOAD ? RUN :
             r_state == RUN  ? (r_i == LAST ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_angle <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_i     <= '0;
      r_neg   <= 1'b0;
      cos_out <= '0;
      sin_out <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_angle <= angle_in;
            busy    <= 1'b1;
          end
        end
        LOAD: begin
          r_x   <= K_INIT;
          r_y   <= '0;
          r_z   <= w_z0;
          r_neg <= w_neg;
          r_i   <= '0;
        end
        RUN: begin
          r_x <= w_pos ? r_x - w_ys : r_x + w_ys;
          r_y <= w_pos ? r_y + w_xs : r_y - w_xs;
          r_z <= w_pos ? r_z - w_atan : r_z + w_atan;
          r_i <= r_i + 5'd1;
        end
        default: begin
          cos_out <= r_neg ? -w_cr : w_cr;
          sin_out <= r_neg ? -w_sr : w_sr;
          done    <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_cordic_sincos.sv
// tb_cordic_sincos: randomized self-checking bench for cordic_sincos against a real-math model
module tb_cordic_sincos;
  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               start = 1'b0;
  logic signed [15:0] angle_in = '0;
  logic signed [15:0] cos_out, sin_out;
  logic               done, busy;
  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  cordic_sincos dut (
    .clk(clk), .rst_n(rst_n), .start(start), .angle_in(angle_in),
    .cos_out(cos_out), .sin_out(sin_out), .done(done), .busy(busy)
  );

  function automatic real ref_val(input int a, input bit s);
    int  c = a > 180 ? 180 : a < -180 ? -180 : a;
    real r = real'(c) * 3.14159265358979323846 / 180.0;
    return 16384.0 * (s ? $sin(r) : $cos(r));
  endfunction

  // model: a conversion accepted when idle completes 18 edges later; outputs hold in between
  int  m_cnt = 0;
  int  m_a = 0;
  bit  m_done = 1'b0;
  real m_c = 0.0;
  real m_s = 0.0;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_cnt  <= 0;
      m_done <= 1'b0;
      m_c    <= 0.0;
      m_s    <= 0.0;
    end else begin
      m_done <= 1'b0;
      if (m_cnt == 0) begin
        if (start) begin
          m_cnt <= 18;
          m_a   <= int'(angle_in);
        end
      end else begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_done <= 1'b1;
          m_c    <= ref_val(m_a, 1'b0);
          m_s    <= ref_val(m_a, 1'b1);
        end
      end
    end

  task automatic check_int(input string n, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d want %0d", n, act, exp);
  endtask

  task automatic check_near(input string n, input int act, input real exp);
    real d = real'(act) - exp;
    checks++;
    if (d <= 3.0 && d >= -3.0) passes++;
    else $display("FAIL %s: got %0d want %f +-3", n, act, exp);
  endtask

  always @(negedge clk) begin
    check_int("busy", int'(busy), m_cnt > 0 ? 1 : 0);
    check_int("done", int'(done), int'(m_done));
    check_near("cos", int'(cos_out), m_c);
    check_near("sin", int'(sin_out), m_s);
  end

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 40) begin
      @(negedge clk);
      k++;
    end
    check_int("idle_timeout", int'(busy), 0);
  endtask

  // literal-expectation conversion; rp re-pulses start mid-run with a different angle
  task automatic conv(input int a, input int ec, input int es, input string n, input bit rp);
    int k = 0;
    wait_idle();
    @(negedge clk); #1;
    angle_in = 16'(a);
    start    = 1'b1;
    while (k < 40) begin
      @(negedge clk);
      k++;
      if (done) break;
      #1;
      start    = rp && (k == 5 || k == 10);
      angle_in = 16'($urandom_range(0, 360) - 180);
    end
    start = 1'b0;
    check_int({n, "_latency"}, k - 1, 18);
    check_near({n, "_cos"}, int'(cos_out), real'(ec));
    check_near({n, "_sin"}, int'(sin_out), real'(es));
  endtask

  initial begin
    int last, gap, npulse;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_int("reset_cos", int'(cos_out), 0);
    check_int("reset_sin", int'(sin_out), 0);
    #1 rst_n = 1'b1;
    conv(0, 16384, 0, "a0", 1'b0);
`ifdef CORDIC_SINCOS_ROUND_EN
    check_int("a0_exact_cos", int'(cos_out), 16384);
    check_int("a0_exact_sin", int'(sin_out), 0);
`endif
    conv(30, 14189, 8192, "a30", 1'b0);
    conv(45, 11585, 11585, "a45", 1'b0);
    conv(90, 0, 16384, "a90", 1'b0);
    conv(-90, 0, -16384, "am90", 1'b0);
    conv(180, -16384, 0, "a180", 1'b0);
    conv(300, -16384, 0, "a300", 1'b0);
    conv(-135, -11585, -11585, "am135", 1'b0);
    conv(120, -8192, 14189, "a120_repulse", 1'b1);
    // start held high: back-to-back conversions every 19 cycles
    wait_idle();
    @(negedge clk); #1;
    start = 1'b1;
    last = -1;
    gap = 0;
    npulse = 0;
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      if (done) begin
        if (last >= 0) gap = c - last;
        last = c;
        npulse++;
      end
      #1 angle_in = 16'($urandom_range(0, 400) - 200);
    end
    start = 1'b0;
    check_int("held_pulses", npulse, 3);
    check_int("held_gap", gap, 19);
    // reset in the middle of a run aborts with no done
    wait_idle();
    @(negedge clk); #1;
    angle_in = 16'sd45;
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    repeat (7) @(negedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check_int("abort_busy", int'(busy), 0);
    check_int("abort_done", int'(done), 0);
    check_int("abort_cos", int'(cos_out), 0);
    #1 rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      check_int("abort_no_done", int'(done), 0);
    end
    conv(60, 8192, 14189, "a60", 1'b0);
    // randomized conversions with spurious starts while busy
    for (int t = 0; t < 40; t++) begin
      @(negedge clk); #1;
      angle_in = 16'($urandom_range(0, 440) - 220);
      start = 1'b1;
      for (int c = 0; c < 22; c++) begin
        @(negedge clk); #1;
        start = ($urandom_range(0, 7) == 0);
        angle_in = 16'($urandom_range(0, 440) - 220);
      end
      start = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/cordic_sincos.md
Name: cordic_sincos

Overview:
- Iterative CORDIC in rotation mode. Takes an integer-degree angle and produces cosine and sine; it is the inverse of the vectoring-mode arctangent block in the sensor-fusion IP.
- Used to rebuild unit vectors and rotation terms from fused angles, for example tilt compensation and display of orientation.
- Single start/done handshake, one micro-rotation per clock, fixed 16 iterations.

Parameters:
- ITER, 16, number of micro-rotations; fixed range 1..16, table depth 16.
- K_INIT, 32'h26DD3B6A, initial x = round(0.6072529350 * 2^30); gain-compensated unit vector.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- angle_in  in  16 signed  angle in integer degrees; valid range -180..+180.
- cos_out  out  16 signed  cosine, Q1.14 (16384 = 1.0); registered.
- sin_out  out  16 signed  sine, Q1.14; registered.
- done  out  1  one-cycle pulse when cos_out/sin_out update.
- busy  out  1  high while a conversion is in progress.

Behaviour:
- Reset (rst_n low, async): cos_out=0, sin_out=0, done=0, busy=0, state=IDLE, x/y/z/iteration counter=0.
- Arctangent table: 16 x 32-bit constants, atan(2^-i) in degrees Q16.16, rounded. i=0 is 32'h002D0000; i=1 is 32'h001A90A7.
- State IDLE:
  - done=0.
  - On start=1 the block latches angle_in, sets busy=1 and goes to LOAD.
- State LOAD (1 cycle), range reduction:
  - Clamp angle_in to [-180,180] first.
  - a > 90: z = (a-180)<<16, neg=1.
  - a < -90: z = (a+180)<<16, neg=1.
  - Otherwise: z = a<<16, neg=0.
  - x = K_INIT, y = 0, i = 0.
- State RUN (exactly ITER cycles, i = 0..ITER-1):
  - d = +1 if z >= 0, else -1.
  - x <= x - d*(y>>>i); y <= y + d*(x>>>i); z <= z - d*atan_tbl[i]; i <= i+1.
  - All arithmetic is 32-bit signed; shifts are arithmetic.
  - After the iteration with i=ITER-1, go to DONE.
- State DONE (1 cycle):
  - cos_out = x[31:16], sin_out = y[31:16]; both negated if neg=1.
  - done=1, busy=0, go to IDLE.
- Latency: with the start edge as edge 0, outputs and done are valid after edge ITER+2 (edge 18 at default). done is high for exactly one cycle.
- start while busy=1 is ignored. It is not queued.
- start held high continuously: a new conversion begins on the cycle after done, at the first IDLE sample.
- angle_in may change after the start edge; only the latched value is used.
- Reset mid-conversion aborts immediately and returns all outputs to their reset values. No done pulse is produced.
- cos_out/sin_out hold their last value until the next DONE.

Optional Feature:
- Macro CORDIC_SINCOS_ROUND_EN.
- Defined: in DONE, the block adds 32'h00008000 to x and y before taking [31:16]. It then saturates the result to [-16384, 16384] before negation. Result: cos(0) = 16384 exactly, and |error| <= 2 LSB.
- Undefined: plain truncation of [31:16], with no saturation. cos(0) may read 16383; |error| <= 3 LSB.

Test Plan:
- angle_in=0, start pulse -> done at edge 18; cos_out=16384+-3, sin_out=0+-3; busy high edges 0..17.
- angle_in=30, then 45 -> (cos,sin) = (14189, 8192)+-3, then (11585, 11585)+-3.
- angle_in=90, then -90, then 180 -> (0, 16384), (0, -16384), (-16384, 0), each +-3. Checks the neg path.
- angle_in=300 (clamp), then -135 -> (-16384, 0)+-3; (-11585, -11585)+-3.
- start re-pulsed at edges 5 and 10 of a run -> single done at edge 18, result for original angle; start held high -> back-to-back done pulses every 19 cycles.
- rst_n low at edge 8 of a run -> outputs 0, busy 0, no done; after release, angle_in=60 -> (8192, 14189)+-3.
- With CORDIC_SINCOS_ROUND_EN -> angle 0 gives exactly (16384, 0).
